// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution feeder (state encoding,
// default geometry, counter-width function).
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH
    } state_t;

    localparam int DEF_IM_LEN    = 520;
    localparam int DEF_IM_ROWS   = 520;
    localparam int DEF_UNITS     = 4;
    localparam int WORDS_PER_ROW = DEF_IM_LEN / DEF_UNITS;

    // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_feeder_pix_pack.sv
// N-lane pixel packer: lane 0 can be force-loaded, other lanes are written by
// index, and the word that would complete on the current insert is exposed.
module pix_pack #(
    parameter int N      = 4,
    parameter int LANE_W = 2
)(
    input  logic              clk,
    input  logic              i_load0,
    input  logic              i_insert,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [7:0]        i_data,
    output logic [N*8-1:0]    o_word,
    output logic              o_complete
);

    logic [N*8-1:0] r_word;
    logic [N*8-1:0] w_word;

    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if ((i_load0 && k == 0) ||
                (i_insert && !i_load0 && i_lane == LANE_W'(k))) begin
                r_word[k*8 +: 8] <= i_data;
            end
        end
    end

    // The top lane is taken straight from the input so the word can be registered on its last handshake.
    always_comb begin
        w_word                = r_word;
        w_word[N*8-1 -: 8]    = i_data;
    end

    assign o_word     = w_word;
    assign o_complete = i_insert && (i_lane == LANE_W'(N - 1));

endmodule

// File: rtl/conv_feeder.sv
// Raster pixel stream to parallel-word feeder for the 3x3 convolver, with frame
// framing, line-buffer clear and post-frame flush. Define CONV_FEEDER_EDGE_REP_EN
// to flush with the last image word instead of zeros.
module conv_feeder
    import conv_pkg::*;
#(
    parameter int IM_LEN            = DEF_IM_LEN,
    parameter int IM_ROWS           = DEF_IM_ROWS,
    parameter int NO_PARALLEL_UNITS = DEF_UNITS,
    parameter int FLUSH_WORDS       = 2*IM_LEN/NO_PARALLEL_UNITS+1
)(
    input  logic                           clk,
    input  logic                           res,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [7:0]                     s_data,
    input  logic                           s_sof,
    output logic [NO_PARALLEL_UNITS*8-1:0] data_out,
    output logic [1:0]                     rowend,
    output logic                           clrbuffer,
    output logic                           stall,
    output logic                           frame_done,
    output logic                           err_sof
);

    localparam int DW     = NO_PARALLEL_UNITS * 8;
    localparam int WPR    = IM_LEN / NO_PARALLEL_UNITS;
    localparam int LANE_W = cnt_w(NO_PARALLEL_UNITS);
    localparam int COL_W  = cnt_w(WPR);
    localparam int ROW_W  = cnt_w(IM_ROWS);
    localparam int FL_W   = cnt_w(FLUSH_WORDS + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WPR - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IM_ROWS - 1);
    localparam logic [FL_W-1:0]  FL_END   = FL_W'(FLUSH_WORDS);

    state_t             r_state, w_state_nxt;
    logic [LANE_W-1:0]  r_lane,  w_lane_nxt;
    logic [COL_W-1:0]   r_col,   w_col_nxt;
    logic [ROW_W-1:0]   r_row,   w_row_nxt;
    logic [FL_W-1:0]    r_fcnt,  w_fcnt_nxt;
    logic [DW-1:0]      r_data_out, w_data_nxt;
    logic [1:0]         r_rowend,   w_rowend_nxt;
    logic               r_clr,   w_clr_nxt;
    logic               r_stall, w_stall_nxt;
    logic               r_done,  w_done_nxt;
    logic               r_err,   w_err_nxt;
    logic               r_s_ready, w_ready_nxt;

    logic               w_hs;
    logic               w_cnt_zero;
    logic               w_sof_err;
    logic               w_load0;
    logic               w_insert;
    logic [DW-1:0]      w_word;
    logic               w_word_done;
    logic [DW-1:0]      w_flush_word;

    assign w_hs       = s_valid & r_s_ready;
    assign w_cnt_zero = (r_lane == '0) && (r_col == '0) && (r_row == '0);
    assign w_sof_err  = (r_state == STREAM) && w_hs && s_sof && !w_cnt_zero;
    assign w_load0    = ((r_state == IDLE) && w_hs && s_sof) || w_sof_err;
    assign w_insert   = (r_state == STREAM) && w_hs && !w_sof_err;

    pix_pack #(
        .N      (NO_PARALLEL_UNITS),
        .LANE_W (LANE_W)
    ) u_pack (
        .clk        (clk),
        .i_load0    (w_load0),
        .i_insert   (w_insert),
        .i_lane     (r_lane),
        .i_data     (s_data),
        .o_word     (w_word),
        .o_complete (w_word_done)
    );

`ifdef CONV_FEEDER_EDGE_REP_EN
    logic [DW-1:0] r_last_word;

    always_ff @(posedge clk) begin
        if (w_word_done) begin
            r_last_word <= w_word;
        end
    end

    assign w_flush_word = r_last_word;
`else
    assign w_flush_word = '0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_lane_nxt   = r_lane;
        w_col_nxt    = r_col;
        w_row_nxt    = r_row;
        w_fcnt_nxt   = r_fcnt;
        w_data_nxt   = r_data_out;
        w_rowend_nxt = r_rowend;
        w_stall_nxt  = 1'b1;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_load0) begin
                    w_lane_nxt  = LANE_W'(1);
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_state_nxt = STREAM;
            end
            STREAM: begin
                if (w_sof_err) begin
                    // Restart the frame on the offending pixel; the partial word is abandoned.
                    w_err_nxt   = 1'b1;
                    w_lane_nxt  = LANE_W'(1);
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = CLEAR;
                end else if (w_word_done) begin
                    w_data_nxt   = w_word;
                    w_stall_nxt  = 1'b0;
                    w_rowend_nxt = {r_row == ROW_LAST, r_col == COL_LAST};
                    w_lane_nxt   = '0;
                    if (r_col == COL_LAST) begin
                        w_col_nxt = '0;
                        if (r_row == ROW_LAST) begin
                            w_row_nxt   = '0;
                            w_fcnt_nxt  = '0;
                            w_state_nxt = FLUSH;
                        end else begin
                            w_row_nxt = r_row + ROW_W'(1);
                        end
                    end else begin
                        w_col_nxt = r_col + COL_W'(1);
                    end
                end else if (w_insert) begin
                    w_lane_nxt = r_lane + LANE_W'(1);
                end
            end
            FLUSH: begin
                if (r_fcnt == FL_END) begin
                    w_done_nxt  = 1'b1;
                    w_fcnt_nxt  = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_data_nxt   = w_flush_word;
                    w_rowend_nxt = 2'b00;
                    w_stall_nxt  = 1'b0;
                    w_fcnt_nxt   = r_fcnt + FL_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_clr_nxt   = (w_state_nxt == CLEAR);
        w_ready_nxt = (w_state_nxt == IDLE) || (w_state_nxt == STREAM);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state    <= IDLE;
            r_lane     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_fcnt     <= '0;
            r_data_out <= '0;
            r_rowend   <= 2'b00;
            r_clr      <= 1'b0;
            r_stall    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_s_ready  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lane     <= w_lane_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_fcnt     <= w_fcnt_nxt;
            r_data_out <= w_data_nxt;
            r_rowend   <= w_rowend_nxt;
            r_clr      <= w_clr_nxt;
            r_stall    <= w_stall_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_s_ready  <= w_ready_nxt;
        end
    end

    assign s_ready    = r_s_ready;
    assign data_out   = r_data_out;
    assign rowend     = r_rowend;
    assign clrbuffer  = r_clr;
    assign stall      = r_stall;
    assign frame_done = r_done;
    assign err_sof    = r_err;

endmodule

// File: doc/conv_feeder.md
Name: conv_feeder

Overview:
- Upstream stage of the 3x3 Gaussian convolution unit. Accepts a raster pixel stream, one 8-bit pixel per cycle, over a valid/ready handshake.
- Packs NO_PARALLEL_UNITS pixels into one parallel word and drives the convolver's data_in, rowend, clrbuffer and stall controls.
- Frames the image with row/column counters. After the last row it drains the convolver's two-line buffer with zero words.

Parameters:
- IM_LEN, 520: pixels per row; must be a multiple of NO_PARALLEL_UNITS.
- IM_ROWS, 520: rows per frame.
- NO_PARALLEL_UNITS, 4: pixels per output word.
- FLUSH_WORDS, 2*IM_LEN/NO_PARALLEL_UNITS+1: zero words emitted after the last pixel.

Ports:
- clk  in  1  Single clock; all logic is on its rising edge.
- res  in  1  Asynchronous, active-low reset.
- s_valid  in  1  Input pixel valid.
- s_ready  out  1  Input pixel accepted when s_valid&s_ready.
- s_data  in  8  Input pixel.
- s_sof  in  1  Qualifies s_data as the first pixel of a frame.
- data_out  out  NO_PARALLEL_UNITS*8  Packed word; pixel k sits at bits [8k+7:8k]; earliest pixel at k=0.
- rowend  out  2  Bit0 = word is the last of its row; bit1 = word belongs to the last row.
- clrbuffer  out  1  One-cycle pulse that clears the convolver line buffers.
- stall  out  1  1 = data_out is not a new word this cycle.
- frame_done  out  1  One-cycle pulse when the flush completes.
- err_sof  out  1  One-cycle pulse when s_sof arrives mid-frame.

Behaviour:
- Reset (res=0, asynchronous): state=IDLE; counters 0; data_out=0, rowend=0, clrbuffer=0, stall=1, frame_done=0, err_sof=0, s_ready=0. This applies at any time, including mid-frame; no partial word is emitted afterwards.
- All outputs are registered.
- Counters:
  - lane 0..N-1;
  - col 0..IM_LEN/N-1 (in words);
  - row 0..IM_ROWS-1.
- FSM states:
  - IDLE: s_ready=1. Pixels without s_sof are discarded. On s_valid&s_sof: capture the pixel into lane 0 and go to CLEAR.
  - CLEAR: one cycle. clrbuffer=1, s_ready=0, stall=1. Next state STREAM.
  - STREAM: s_ready=1. Each accepted pixel fills the next lane. On the handshake that completes lane N-1:
    - next cycle data_out=packed word, stall=0;
    - rowend[0]=(col==IM_LEN/N-1), rowend[1]=(row==IM_ROWS-1);
    - col/row advance, wrapping col to 0 at row end.
  - STREAM, all other cycles: stall=1; data_out and rowend hold.
  - STREAM exit: the word with row==IM_ROWS-1 and col==last moves the FSM to FLUSH.
  - FLUSH: s_ready=0. Emits FLUSH_WORDS consecutive words with data_out=0, rowend=00, stall=0, one per cycle. After the final word: frame_done=1 for one cycle, stall=1, state IDLE.
- Mid-frame s_sof (s_valid&s_sof accepted in STREAM with lane/col/row not all zero):
  - err_sof pulses;
  - the partial word is dropped;
  - the pixel is captured into lane 0, counters reset, state CLEAR.
- s_sof on the exact first pixel of STREAM (all counters 0) is legal and is not an error.
- A gap in s_valid simply extends stall=1. There is no timeout.
- Latency: one cycle from the handshake of the Nth pixel to stall=0 with that word.
- Throughput: one word per N accepted pixels; one word per cycle during FLUSH.

Optional Feature:
- Macro: CONV_FEEDER_EDGE_REP_EN.
- Defined: FLUSH repeats the last emitted image word instead of zero words, giving replicated-border behaviour at the frame bottom. rowend is still 00 during FLUSH.
- Undefined: FLUSH emits zero words as above. The extra word register is removed.

Decomposition:
- Shared package conv_pkg holds:
  - the state enum (IDLE, CLEAR, STREAM, FLUSH);
  - localparam WORDS_PER_ROW=IM_LEN/NO_PARALLEL_UNITS;
  - the lane/col/row counter width functions (clog2).
- One sub-module, pix_pack: an N-lane shift/insert register with load-lane-0, insert and word-complete outputs.
- The FSM, counters and output registers live in conv_feeder.

Test Plan (IM_LEN=8, IM_ROWS=3, N=4, FLUSH_WORDS=5 unless stated):
1. Stream pixels 1..24 continuously, sof on pixel 1 -> clrbuffer one cycle after sof, then:
   - 6 words with stall=0: first data_out=0x04030201;
   - rowend sequence 00,01,00,01,10,11;
   - then 5 zero words, then frame_done pulse.
2. Insert 3-cycle s_valid gaps between every pixel -> same 6 words and rowend sequence; stall=1 on every cycle without a new word.
3. s_sof on pixel 11 mid-frame -> err_sof pulse; words 0x04030201 and 0x08070605 are already out; clrbuffer pulses; the next word starts with pixel 11 at lane 0.
4. Pixels without sof in IDLE -> no words emitted, stall=1 throughout, s_ready=1.
5. Assert res=0 while lane=2 of word 3 -> all outputs at reset values in the same cycle. After release and a new sof frame, the output is identical to scenario 1.
6. With CONV_FEEDER_EDGE_REP_EN defined and scenario 1 stimulus -> 5 FLUSH words equal 0x18171615.
